modulation_sequencer: RTL and testbench



---
 rtl/modulation_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_modulation_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modulation_sequencer.sv
// Run sequencer for an FFT-based modulation classifier: captures FRAMES frames,
// runs the detector on each one, then majority-votes the detected classes.
module modulation_sequencer #(
    parameter int FRAMES    = 5,
    parameter int FRAME_LEN = 256,
    parameter int TIMEOUT   = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr_en_in,
    input  logic [7:0] wr_addr_in,
    output logic       fft_req,
    output logic       det_en,
    output logic       det_key,
    input  logic       det_valid,
    input  logic [2:0] det_mode,
    output logic [2:0] mode_out,
    output logic       mode_valid,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_seq
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, CAPTURE, DETECT, RESTART, VOTE, DONE
    } stateT;

    stateT         state_q;
    logic          startPrev_q;
    logic [8:0]    wrCnt_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    frameCnt_q;
    logic [2:0]    cntA_q;
    logic [2:0]    cntB_q;
    logic [2:0]    cntC_q;
    logic          restartCnt_q;
    logic          fftReq_q;
    logic          detEn_q;
    logic          detKey_q;
    logic [2:0]    modeOut_q;
    logic          modeValid_q;
    logic          errTimeout_q;
    logic          errSeq_q;

    logic          startEdge;
    logic          timerExpired;
    logic          wrMatch;
    logic [2:0]    voteMode_d;

    assign startEdge    = start & ~startPrev_q;
    assign timerExpired = (timer_q == TW'(TIMEOUT - 1));
    assign wrMatch      = ({1'b0, wr_addr_in} == wrCnt_q);

    // Ties favour 010, then 001, then 100; an empty tally reports no class.
    always_comb begin
        voteMode_d = 3'b000;
        if ((cntA_q | cntB_q | cntC_q) != 3'd0) begin
            if (cntB_q >= cntA_q && cntB_q >= cntC_q) begin
                voteMode_d = 3'b010;
            end else if (cntA_q >= cntC_q) begin
                voteMode_d = 3'b001;
            end else begin
                voteMode_d = 3'b100;
            end
        end
    end

    always_ff @(posedge clk) begin
        startPrev_q <= start;
        if (rst) begin
            state_q      <= IDLE;
            startPrev_q  <= 1'b0;
            wrCnt_q      <= '0;
            timer_q      <= '0;
            frameCnt_q   <= '0;
            cntA_q       <= '0;
            cntB_q       <= '0;
            cntC_q       <= '0;
            restartCnt_q <= 1'b0;
            fftReq_q     <= 1'b0;
            detEn_q      <= 1'b0;
            detKey_q     <= 1'b1;
            modeOut_q    <= 3'b000;
            modeValid_q  <= 1'b0;
            errTimeout_q <= 1'b0;
            errSeq_q     <= 1'b0;
        end else begin
            fftReq_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (startEdge) begin
                        frameCnt_q   <= '0;
                        cntA_q       <= '0;
                        cntB_q       <= '0;
                        cntC_q       <= '0;
                        errTimeout_q <= 1'b0;
                        errSeq_q     <= 1'b0;
                        modeValid_q  <= 1'b0;
                        modeOut_q    <= 3'b000;
                        fftReq_q     <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    wrCnt_q <= '0;
                    timer_q <= '0;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    timer_q <= timer_q + 1'b1;
                    if (wrCnt_q == 9'(FRAME_LEN)) begin
                        timer_q <= '0;
                        detEn_q <= 1'b1;
                        state_q <= DETECT;
                    end else if (timerExpired) begin
                        errTimeout_q <= 1'b1;
                        detKey_q     <= 1'b0;
                        restartCnt_q <= 1'b0;
                        state_q      <= RESTART;
                    end else if (wr_en_in) begin
                        if (wrMatch) begin
                            wrCnt_q <= wrCnt_q + 9'd1;
                        end else begin
                            // A stray address 0 is treated as the first word of a fresh frame.
                            errSeq_q <= 1'b1;
                            wrCnt_q  <= (wr_addr_in == 8'd0) ? 9'd1 : 9'd0;
                        end
                    end
                end
                DETECT: begin
                    timer_q <= timer_q + 1'b1;
                    // det_valid wins over a simultaneous expiry.
                    if (det_valid || timerExpired) begin
                        detEn_q      <= 1'b0;
                        detKey_q     <= 1'b0;
                        restartCnt_q <= 1'b0;
                        state_q      <= RESTART;
                        if (det_valid) begin
                            case (det_mode)
                                3'b001:  cntA_q <= cntA_q + 3'd1;
                                3'b010:  cntB_q <= cntB_q + 3'd1;
                                3'b100:  cntC_q <= cntC_q + 3'd1;
                                default: errSeq_q <= 1'b1;
                            endcase
                        end else begin
                            errTimeout_q <= 1'b1;
                        end
                    end
                end
                RESTART: begin
                    restartCnt_q <= 1'b1;
                    if (restartCnt_q) begin
                        detKey_q   <= 1'b1;
                        frameCnt_q <= frameCnt_q + 3'd1;
                        if (frameCnt_q + 3'd1 == 3'(FRAMES)) begin
                            state_q <= VOTE;
                        end else begin
                            fftReq_q <= 1'b1;
                            state_q  <= REQ;
                        end
                    end
                end
                VOTE: begin
                    modeOut_q   <= voteMode_d;
                    modeValid_q <= 1'b1;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fft_req     = fftReq_q;
    assign det_en      = detEn_q;
    assign det_key     = detKey_q;
    assign mode_out    = modeOut_q;
    assign mode_valid  = modeValid_q;
    assign err_timeout = errTimeout_q;
    assign err_seq     = errSeq_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_modulation_sequencer.sv
// Directed bench for modulation_sequencer: drives whole runs of frames with a
// simple detector model and compares against hand-computed votes and flags.
`timescale 1ns/1ps
module tb_modulation_sequencer;

    // Timeout sized above one full 256-word capture so only a withheld det_valid expires.
    localparam int FRAMES    = 5;
    localparam int FRAME_LEN = 256;
    localparam int TIMEOUT   = 400;

    logic       clk;
    logic       rst;
    logic       start;
    logic       wr_en_in;
    logic [7:0] wr_addr_in;
    logic       fft_req;
    logic       det_en;
    logic       det_key;
    logic       det_valid;
    logic [2:0] det_mode;
    logic [2:0] mode_out;
    logic       mode_valid;
    logic       busy;
    logic       err_timeout;
    logic       err_seq;

    int testsRun    = 0;
    int testsFailed = 0;
    int reqPulses   = 0;

    modulation_sequencer #(
        .FRAMES(FRAMES),
        .FRAME_LEN(FRAME_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .wr_en_in(wr_en_in),
        .wr_addr_in(wr_addr_in),
        .fft_req(fft_req),
        .det_en(det_en),
        .det_key(det_key),
        .det_valid(det_valid),
        .det_mode(det_mode),
        .mode_out(mode_out),
        .mode_valid(mode_valid),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_seq(err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fft_req) reqPulses <= reqPulses + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic writeRange(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            wr_en_in   = 1'b1;
            wr_addr_in = 8'(a);
            tick;
        end
        wr_en_in = 1'b0;
    endtask

    // glitch: 0 clean, 1 skip to address 20, 2 restart at address 0, 3 start pulse mid-capture
    task automatic runFrame(input logic [2:0] mode, input logic giveValid, input logic [1:0] glitch);
        int n;
        n = 0;
        while (!fft_req && n < 10) begin
            tick;
            n++;
        end
        checkOutput("fftReqSeen", fft_req, 1);
        tick;
        checkOutput("fftReqOneCycle", fft_req, 0);
        case (glitch)
            2'd1: begin
                writeRange(0, 9);
                writeRange(20, 20);
                checkOutput("errSeqOnSkip", err_seq, 1);
                writeRange(0, 255);
            end
            2'd2: begin
                writeRange(0, 9);
                writeRange(0, 255);
            end
            2'd3: begin
                writeRange(0, 99);
                start = 1'b1;
                writeRange(100, 100);
                start = 1'b0;
                writeRange(101, 255);
            end
            default: writeRange(0, 255);
        endcase
        n = 0;
        while (!det_en && n < 20) begin
            tick;
            n++;
        end
        checkOutput("detEnLatency", n, 1);
        if (giveValid) begin
            det_valid = 1'b1;
            det_mode  = mode;
            tick;
            det_valid = 1'b0;
            det_mode  = 3'b000;
            checkOutput("detEnDrop", det_en, 0);
            checkOutput("detKeyLow", det_key, 0);
        end else begin
            n = 0;
            while (det_en && n < TIMEOUT + 100) begin
                tick;
                n++;
            end
            checkOutput("detectTimeout", n, TIMEOUT);
            checkOutput("errTimeoutSet", err_timeout, 1);
        end
    endtask

    task automatic pulseStart;
        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("startBusy", busy, 1);
        checkOutput("startValidClr", mode_valid, 0);
        checkOutput("startErrTClr", err_timeout, 0);
        checkOutput("startErrSClr", err_seq, 0);
    endtask

    task automatic applyStimulus(input logic [14:0] modes, input logic [4:0] valids, input logic [9:0] glitches);
        int base;
        base = reqPulses;
        pulseStart;
        for (int f = 0; f < FRAMES; f++) begin
            runFrame(modes[3*f +: 3], valids[f], glitches[2*f +: 2]);
        end
        checkOutput("fftReqPulses", reqPulses - base, FRAMES);
    endtask

    // Walks RESTART x2, VOTE, DONE after the last frame and checks the result.
    task automatic checkResult(input logic [2:0] expMode, input logic expErrT, input logic expErrS);
        tick;
        checkOutput("detKeyHold", det_key, 0);
        tick;
        checkOutput("detKeyRelease", det_key, 1);
        checkOutput("validEarly", mode_valid, 0);
        checkOutput("voteBusy", busy, 1);
        tick;
        checkOutput("modeValid", mode_valid, 1);
        checkOutput("modeOut", mode_out, expMode);
        checkOutput("doneBusy", busy, 0);
        checkOutput("errTimeout", err_timeout, expErrT);
        checkOutput("errSeq", err_seq, expErrS);
        tick;
        tick;
        checkOutput("modeOutHeld", mode_out, expMode);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        wr_en_in   = 1'b0;
        wr_addr_in = 8'd0;
        det_valid  = 1'b0;
        det_mode   = 3'b000;
        tick;
        tick;
        checkOutput("rstFftReq", fft_req, 0);
        checkOutput("rstDetEn", det_en, 0);
        checkOutput("rstDetKey", det_key, 1);
        checkOutput("rstModeOut", mode_out, 0);
        checkOutput("rstModeValid", mode_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstErrT", err_timeout, 0);
        checkOutput("rstErrS", err_seq, 0);
        rst = 1'b0;
        tick;

        $display("[TB] clean run, all 010, start pulse ignored mid-capture");
        applyStimulus({5{3'b010}}, 5'b11111, 10'b00_00_00_11_00);
        checkResult(3'b010, 1'b0, 1'b0);

        $display("[TB] tie between 001 and 100");
        applyStimulus({3'b010, 3'b100, 3'b001, 3'b100, 3'b001}, 5'b11111, 10'd0);
        checkResult(3'b001, 1'b0, 1'b0);

        $display("[TB] frame 3 times out, rest vote 100");
        applyStimulus({5{3'b100}}, 5'b11011, 10'd0);
        checkResult(3'b100, 1'b1, 1'b0);

        $display("[TB] write-address sequence errors");
        applyStimulus({5{3'b001}}, 5'b11111, 10'b00_00_00_10_01);
        checkResult(3'b001, 1'b0, 1'b1);

        $display("[TB] invalid det_mode code");
        applyStimulus({3'b100, 3'b001, 3'b001, 3'b011, 3'b010}, 5'b11111, 10'd0);
        checkResult(3'b001, 1'b0, 1'b1);

        $display("[TB] every frame times out");
        applyStimulus(15'd0, 5'b00000, 10'd0);
        checkResult(3'b000, 1'b1, 1'b0);

        $display("[TB] reset during DETECT");
        pulseStart;
        n = 0;
        while (!fft_req && n < 10) begin
            tick;
            n++;
        end
        tick;
        writeRange(0, 255);
        n = 0;
        while (!det_en && n < 20) begin
            tick;
            n++;
        end
        checkOutput("preResetDetEn", det_en, 1);
        rst = 1'b1;
        tick;
        checkOutput("midRstDetEn", det_en, 0);
        checkOutput("midRstDetKey", det_key, 1);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstModeValid", mode_valid, 0);
        checkOutput("midRstModeOut", mode_out, 0);
        rst = 1'b0;
        tick;
        checkOutput("postRstBusy", busy, 0);
        checkOutput("postRstFftReq", fft_req, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
